// File: rtl/key_token_pkg.sv
// key_token_pkg: command codes, FSM states and operand shifter opcodes for key_token_assembler
package key_token_pkg;
   localparam logic [4:0] CODE_EXE  = 5'b10011;
   localparam logic [4:0] CODE_BKSP = 5'b10101;
   localparam logic [4:0] CODE_CE   = 5'b10110;
   localparam logic [4:0] CODE_CLR  = 5'b10111;
   localparam int P_ERR = 0, P_CLR = 1, P_CE = 2, P_EXE = 3, P_OPV = 4, P_OK = 5;
   typedef enum logic [1:0] {IDLE, ENTRY, OP_PENDING} state_t;
   typedef enum logic [2:0] {SH_HOLD, SH_PUSH, SH_LOAD, SH_CLEAR, SH_BKSP} sh_op_t;
endpackage

// File: rtl/operand_shifter.sv
// operand_shifter: nibble-wide operand register with push, load, clear and backspace
module operand_shifter
   import key_token_pkg::*;
#(
   parameter int N_DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  sh_op_t                op,
   input  logic [3:0]            digit,
   output logic [4*N_DIGITS-1:0] operand
);
   localparam int W = 4*N_DIGITS;
   always_ff @(posedge clk)
      if (reset) operand <= '0;
      else operand <= op == SH_PUSH  ? (operand << 4) | W'(digit) :
                      op == SH_LOAD  ? W'(digit) :
                      op == SH_CLEAR ? '0 :
                      op == SH_BKSP  ? operand >> 4 : operand;
endmodule

// File: rtl/key_token_assembler.sv
// key_token_assembler: assembles keypad digits and operators into operand/operation tokens
// Optional TOKEN_BACKSPACE_EN turns code 1_0101 into a backspace instead of an operator.
module key_token_assembler
   import key_token_pkg::*;
#(
   parameter int N_DIGITS = 4,
   parameter int DECIMAL  = 1,
   localparam int CW = $clog2(N_DIGITS+1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4:0]            val,
   input  logic                  BTNCp,
   output logic [4*N_DIGITS-1:0] operand,
   output logic [CW-1:0]         digit_cnt,
   output logic [4:0]            operation,
   output logic                  ok,
   output logic                  op_valid,
   output logic                  EXE,
   output logic                  CE,
   output logic                  CLR,
   output logic                  err
);
   state_t state, n_state;
   sh_op_t sh_op;
   logic [CW-1:0] n_cnt;
   logic [4:0] n_operation;
   logic [5:0] pulse, n_pulse;
   logic bad_digit, full;
   assign bad_digit = (DECIMAL != 0) && (val[3:0] > 4'd9);
   assign full = (state == ENTRY) && (digit_cnt == CW'(N_DIGITS));
   always_comb begin
      sh_op = SH_HOLD;
      n_cnt = digit_cnt;
      n_state = state;
      n_operation = operation;
      n_pulse = '0;
      if (BTNCp) begin
         if (!val[4]) begin
            if (bad_digit || full) n_pulse[P_ERR] = 1'b1;
            else begin
               sh_op = state == ENTRY ? SH_PUSH : SH_LOAD;
               n_cnt = state == ENTRY ? digit_cnt + CW'(1) : CW'(1);
               n_state = ENTRY;
               n_pulse[P_OK] = 1'b1;
            end
         end else if (val == CODE_EXE) begin
            n_state = IDLE;
            n_pulse[P_EXE] = 1'b1;
         end else if (val == CODE_CE) begin
            sh_op = SH_CLEAR;
            n_cnt = '0;
            n_state = state == ENTRY ? IDLE : state;
            n_pulse[P_CE] = 1'b1;
         end else if (val == CODE_CLR) begin
            sh_op = SH_CLEAR;
            n_cnt = '0;
            n_operation = '0;
            n_state = IDLE;
            n_pulse[P_CLR] = 1'b1;
         end
`ifdef TOKEN_BACKSPACE_EN
         else if (val == CODE_BKSP) begin
            if (state == ENTRY && digit_cnt != '0) begin
               sh_op = SH_BKSP;
               n_cnt = digit_cnt - CW'(1);
               n_state = digit_cnt == CW'(1) ? IDLE : ENTRY;
               n_pulse[P_OK] = 1'b1;
            end else n_pulse[P_ERR] = 1'b1;
         end
`endif
         else begin
            n_operation = val;
            n_state = OP_PENDING;
            n_pulse[P_OPV] = 1'b1;
         end
      end
   end
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         digit_cnt <= '0;
         operation <= '0;
         pulse <= '0;
      end else begin
         state <= n_state;
         digit_cnt <= n_cnt;
         operation <= n_operation;
         pulse <= n_pulse;
      end
   assign {ok, op_valid, EXE, CE, CLR, err} = pulse;
   operand_shifter #(.N_DIGITS(N_DIGITS)) u_shifter (
      .clk    (clk),
      .reset  (reset),
      .op     (sh_op),
      .digit  (val[3:0]),
      .operand(operand)
   );
endmodule

// File: tb/tb_key_token_assembler.sv
// tb_key_token_assembler: directed checks of decimal and hex key_token_assembler instances
module tb_key_token_assembler;
   logic clk = 1'b0, reset = 1'b1, BTNCp = 1'b0;
   logic [4:0] val = '0;
   logic [15:0] operand_a, operand_b;
   logic [2:0] cnt_a, cnt_b;
   logic [4:0] operation_a, operation_b;
   logic ok_a, opv_a, exe_a, ce_a, clr_a, err_a;
   logic ok_b, opv_b, exe_b, ce_b, clr_b, err_b;
   logic [5:0] pa, pb;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   assign pa = {ok_a, opv_a, exe_a, ce_a, clr_a, err_a};
   assign pb = {ok_b, opv_b, exe_b, ce_b, clr_b, err_b};
   key_token_assembler #(.N_DIGITS(4), .DECIMAL(1)) dut_a (
      .clk(clk), .reset(reset), .val(val), .BTNCp(BTNCp),
      .operand(operand_a), .digit_cnt(cnt_a), .operation(operation_a),
      .ok(ok_a), .op_valid(opv_a), .EXE(exe_a), .CE(ce_a), .CLR(clr_a), .err(err_a)
   );
   key_token_assembler #(.N_DIGITS(4), .DECIMAL(0)) dut_b (
      .clk(clk), .reset(reset), .val(val), .BTNCp(BTNCp),
      .operand(operand_b), .digit_cnt(cnt_b), .operation(operation_b),
      .ok(ok_b), .op_valid(opv_b), .EXE(exe_b), .CE(ce_b), .CLR(clr_b), .err(err_b)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic press(input logic [4:0] v);
      @(negedge clk);
      val = v;
      BTNCp = 1'b1;
      @(negedge clk);
      BTNCp = 1'b0;
   endtask
   task automatic check_a(input string tag, input logic [15:0] opd, input logic [2:0] cnt,
                          input logic [4:0] opn, input logic [5:0] pul);
      check({tag, ".operand"}, operand_a, opd);
      check({tag, ".cnt"}, cnt_a, cnt);
      check({tag, ".operation"}, operation_a, opn);
      check({tag, ".pulses"}, pa, pul);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      check_a("reset", 16'h0, 3'd0, 5'h00, 6'b000000);
      reset = 1'b0;
      press(5'h01);
      check_a("d1", 16'h0001, 3'd1, 5'h00, 6'b100000);
      press(5'h02);
      press(5'h03);
      check_a("d123", 16'h0123, 3'd3, 5'h00, 6'b100000);
      @(negedge clk);
      check("idle_pulses", pa, 6'b000000);
      press(5'h04);
      check_a("d1234", 16'h1234, 3'd4, 5'h00, 6'b100000);
      press(5'h05);
      check_a("full", 16'h1234, 3'd4, 5'h00, 6'b000001);
      press(5'h10);
      check_a("op_full", 16'h1234, 3'd4, 5'h10, 6'b010000);
      press(5'h17);
      check_a("clr1", 16'h0, 3'd0, 5'h00, 6'b000010);
      press(5'h07);
      press(5'h10);
      check_a("op_after7", 16'h0007, 3'd1, 5'h10, 6'b010000);
      press(5'h11);
      check_a("op_replace", 16'h0007, 3'd1, 5'h11, 6'b010000);
      press(5'h08);
      check_a("d8_after_op", 16'h0008, 3'd1, 5'h11, 6'b100000);
      press(5'h0A);
      check_a("dec_A", 16'h0008, 3'd1, 5'h11, 6'b000001);
      check("hex_A.operand", operand_b, 16'h008A);
      check("hex_A.cnt", cnt_b, 3'd2);
      check("hex_A.pulses", pb, 6'b100000);
      press(5'h13);
      check_a("exe", 16'h0008, 3'd1, 5'h11, 6'b001000);
      press(5'h03);
      check_a("d3_after_exe", 16'h0003, 3'd1, 5'h11, 6'b100000);
      press(5'h05);
      press(5'h06);
      check_a("d356", 16'h0356, 3'd3, 5'h11, 6'b100000);
      press(5'h16);
      check_a("ce", 16'h0, 3'd0, 5'h11, 6'b000100);
      press(5'h09);
      check_a("d9_after_ce", 16'h0009, 3'd1, 5'h11, 6'b100000);
      press(5'h17);
      check_a("clr2", 16'h0, 3'd0, 5'h00, 6'b000010);
      press(5'h04);
      press(5'h02);
      check_a("d42", 16'h0042, 3'd2, 5'h00, 6'b100000);
      press(5'h15);
`ifdef TOKEN_BACKSPACE_EN
      check_a("bksp1", 16'h0004, 3'd1, 5'h00, 6'b100000);
      press(5'h15);
      check_a("bksp2", 16'h0000, 3'd0, 5'h00, 6'b100000);
      press(5'h15);
      check_a("bksp_idle", 16'h0000, 3'd0, 5'h00, 6'b000001);
      press(5'h04);
      press(5'h02);
`else
      check_a("code15_op", 16'h0042, 3'd2, 5'h15, 6'b010000);
      press(5'h02);
`endif
      @(negedge clk);
      reset = 1'b1;
      val = 5'h09;
      BTNCp = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      BTNCp = 1'b0;
      check_a("reset_btn", 16'h0, 3'd0, 5'h00, 6'b000000);
      press(5'h01);
      check_a("post_reset", 16'h0001, 3'd1, 5'h00, 6'b100000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
